// File: rtl/spike_accumulator.sv
// spike_accumulator: per-synapse spike-weight integrator for an integrate-and-fire neuron.
// Optional saturation instead of wraparound when SPIKE_ACC_SATURATE_EN is defined.
module spike_accumulator #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spike_in,
  input  logic [DATA_WIDTH-1:0] spike_weight,
  output logic [DATA_WIDTH-1:0] dout
);

  logic                  spike_q;
  logic                  rise;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_nxt;

  assign rise = spike_in & ~spike_q;

`ifdef SPIKE_ACC_SATURATE_EN
  logic [DATA_WIDTH:0] sum;

  assign sum = {1'b0, acc} + {1'b0, spike_weight};

  // Clamp to all-ones on carry-out; all-ones plus anything stays all-ones
  always_comb begin
    acc_nxt = sum[DATA_WIDTH-1:0];
    if (sum[DATA_WIDTH])
      acc_nxt = {DATA_WIDTH{1'b1}};
  end
`else
  // Plain modulo-2**DATA_WIDTH add, carry dropped
  always_comb begin
    acc_nxt = acc + spike_weight;
  end
`endif

  // Edge-detect history and running total; only a 0->1 edge adds weight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_q <= 1'b0;
      acc     <= '0;
    end else begin
      spike_q <= spike_in;
      if (rise)
        acc <= acc_nxt;
    end
  end

  assign dout = acc;

endmodule

// File: tb/tb_spike_accumulator.sv
// tb_spike_accumulator: table-driven and sequence checks for spike_accumulator.
// Runs a 32-bit instance for counting and an 8-bit instance for overflow.
module tb_spike_accumulator;

  logic        clk;
  logic        rst;
  logic        s32;
  logic [31:0] w32;
  logic [31:0] d32;
  logic        s8;
  logic [7:0]  w8;
  logic [7:0]  d8;

  int n_cmp;
  int n_bad;

  typedef struct {
    string       nm;
    bit          use8;
    logic [31:0] exp;
  } sb_t;

  sb_t sbq[$];

  typedef struct {
    logic        r;
    logic        s;
    logic [31:0] w;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  spike_accumulator #(.DATA_WIDTH(32)) u_d32 (
    .clk          (clk),
    .rst          (rst),
    .spike_in     (s32),
    .spike_weight (w32),
    .dout         (d32)
  );

  spike_accumulator #(.DATA_WIDTH(8)) u_d8 (
    .clk          (clk),
    .rst          (rst),
    .spike_in     (s8),
    .spike_weight (w8),
    .dout         (d8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // push expectation, clock once, pop and compare after the edge
  task automatic step(input string nm, input bit use8,
                      input logic [31:0] exp);
    sb_t e;
    sbq.push_back('{nm, use8, exp});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    if (e.use8)
      check(e.nm, {24'd0, d8}, e.exp);
    else
      check(e.nm, d32, e.exp);
  endtask

  task automatic add(input logic r, input logic s,
                     input logic [31:0] w, input logic [31:0] exp);
    vt.push_back('{r, s, w, exp});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    s32   = 1'b0;
    w32   = '0;
    s8    = 1'b0;
    w8    = '0;

    // single 1-cycle pulses, weight 1
    for (int i = 1; i <= 5; i++) begin
      add(0, 1, 1, i);
      add(0, 0, 1, i);
    end
    // held level, weight 7
    add(1, 0, 7, 0);
    for (int i = 0; i < 10; i++)
      add(0, 1, 7, 7);
    add(0, 0, 7, 7);
    add(0, 1, 7, 14);
    add(0, 0, 7, 14);
    // weight changes 3, 0, 100
    add(1, 0, 0, 0);
    add(0, 1, 3, 3);
    add(0, 0, 3, 3);
    add(0, 1, 0, 3);
    add(0, 0, 0, 3);
    add(0, 1, 100, 103);
    add(0, 0, 100, 103);
    // toggle 1,0,1 counts twice
    add(0, 1, 5, 108);
    add(0, 0, 5, 108);
    add(0, 1, 5, 113);

    #3;
    check("reset_d32", d32, 32'd0);
    check("reset_d8", {24'd0, d8}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      rst = vt[i].r;
      s32 = vt[i].s;
      w32 = vt[i].w;
      step($sformatf("vec%0d", i), 1'b0, vt[i].exp);
    end
    rst = 1'b0;
    s32 = 1'b0;
    step("vec_tail", 1'b0, 32'd113);

    // asynchronous reset between edges
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", d32, 32'd0);
    for (int i = 0; i < 3; i++)
      step("rst_hold", 1'b0, 32'd0);
    rst = 1'b0;
    step("rst_rel", 1'b0, 32'd0);

    // reset mid-run with spike held high across release
    s32 = 1'b1;
    w32 = 32'd50;
    step("mid_50", 1'b0, 32'd50);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst", d32, 32'd0);
    step("mid_hold1", 1'b0, 32'd0);
    step("mid_hold2", 1'b0, 32'd0);
    rst = 1'b0;
    #1;
    check("mid_prerise", d32, 32'd0);
    step("mid_after", 1'b0, 32'd50);
    step("mid_level", 1'b0, 32'd50);
    s32 = 1'b0;

    // 8-bit overflow, weight 200
    w8 = 8'd200;
    s8 = 1'b1;
    step("ovf_1", 1'b1, 32'd200);
    s8 = 1'b0;
    step("ovf_1l", 1'b1, 32'd200);
    s8 = 1'b1;
`ifdef SPIKE_ACC_SATURATE_EN
    step("ovf_2", 1'b1, 32'd255);
    s8 = 1'b0;
    step("ovf_2l", 1'b1, 32'd255);
    s8 = 1'b1;
    step("ovf_3", 1'b1, 32'd255);
`else
    step("ovf_2", 1'b1, 32'd144);
    s8 = 1'b0;
    step("ovf_2l", 1'b1, 32'd144);
    s8 = 1'b1;
    step("ovf_3", 1'b1, 32'd88);
`endif
    s8 = 1'b0;

    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending expected 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
